// File: rtl/program_loader_if.sv
// Byte-stream valid/ready channel feeding the program loader.
// The source (UART receiver or debug port) is the master; the loader is the slave.
interface program_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/program_loader.sv
// Loads a LEN / data / CHK byte frame into CPU instruction memory as 16-bit
// words (first byte high), checks the XOR checksum and then releases the CPU.
module program_loader #(
    parameter int BASE_INDEX = 10,
    parameter int MAX_WORDS  = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    program_loader_if.slave     rx,
    output logic                write,
    output logic [7:0]          write_instruction_index,
    output logic [15:0]         write_instruction,
    output logic                cpu_hold,
    output logic [7:0]          loaded_count,
    output logic                done,
    output logic                error
);
    localparam logic [7:0] BASE8 = 8'(BASE_INDEX);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_LEN, S_WAIT_HI, S_WAIT_LO, S_WRITE, S_WAIT_CHK, S_DONE, S_ERROR
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] n_words, acc, hi_byte;
    logic       xfer, len_bad, armable;

    assign xfer    = rx.rx_valid & rx.rx_ready;
    assign len_bad = (rx.rx_data == 8'd0) || (int'(rx.rx_data) > MAX_WORDS);
    assign armable = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        rx.rx_ready = 1'b0;
        write       = 1'b0;
        cpu_hold    = 1'b1;
        done        = 1'b0;
        error       = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_WAIT_LEN;
            S_WAIT_LEN: begin
                rx.rx_ready = 1'b1;
                if (xfer) state_nxt = len_bad ? S_ERROR : S_WAIT_HI;
            end
            S_WAIT_HI: begin
                rx.rx_ready = 1'b1;
                if (xfer) state_nxt = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                rx.rx_ready = 1'b1;
                if (xfer) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                write     = 1'b1;
                state_nxt = (loaded_count + 8'd1 == n_words) ? S_WAIT_CHK : S_WAIT_HI;
            end
            S_WAIT_CHK: begin
                rx.rx_ready = 1'b1;
                if (xfer) state_nxt = (rx.rx_data == acc) ? S_DONE : S_ERROR;
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) state_nxt = S_WAIT_LEN;
            end
            S_ERROR: begin
                error = 1'b1;
                if (start) state_nxt = S_WAIT_LEN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Index and word are registered on the low-byte transfer so they are
    // stable during the write cycle and hold afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            loaded_count            <= 8'd0;
            n_words                 <= 8'd0;
            acc                     <= 8'd0;
            hi_byte                 <= 8'd0;
            write_instruction_index <= BASE8;
            write_instruction       <= 16'd0;
        end else begin
            case (state)
                S_WAIT_LEN: if (xfer) begin
                    n_words <= rx.rx_data;
                    acc     <= acc ^ rx.rx_data;
                end
                S_WAIT_HI: if (xfer) begin
                    hi_byte <= rx.rx_data;
                    acc     <= acc ^ rx.rx_data;
                end
                S_WAIT_LO: if (xfer) begin
                    acc                     <= acc ^ rx.rx_data;
                    write_instruction       <= {hi_byte, rx.rx_data};
                    write_instruction_index <= BASE8 + loaded_count;
                end
                S_WRITE: loaded_count <= loaded_count + 8'd1;
                default: if (armable && start) begin
                    loaded_count <= 8'd0;
                    acc          <= 8'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: a frame-position reference model is
// compared against every DUT output on each falling clock edge.
module tb_program_loader;
    localparam int BASE = 10;
    localparam int MAXW = 64;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        write, cpu_hold, done, error;
    logic [7:0]  write_instruction_index, loaded_count;
    logic [15:0] write_instruction;

    int errors = 0;
    int checks = 0;

    program_loader_if rx_if ();

    program_loader #(.BASE_INDEX(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .start(start), .rx(rx_if.slave),
        .write(write), .write_instruction_index(write_instruction_index),
        .write_instruction(write_instruction), .cpu_hold(cpu_hold),
        .loaded_count(loaded_count), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks position within the frame, not loader states.
    bit          m_active = 0, m_done = 0, m_err = 0, m_pend = 0;
    int          m_pos = 0;
    logic [7:0]  m_n = 0, m_acc = 0, m_hi = 0, m_cnt = 0, m_idx = 8'(BASE);
    logic [15:0] m_word = 0;
    logic [7:0]  cap_idx[$];
    logic [15:0] cap_dat[$];

    always @(negedge clk) begin
        logic exp_ready;
        logic [7:0] b;
        exp_ready = m_active && !m_pend;
        chk("rx_ready", 32'(rx_if.rx_ready), 32'(exp_ready));
        chk("write", 32'(write), 32'(m_pend));
        chk("index", 32'(write_instruction_index), 32'(m_idx));
        chk("word", 32'(write_instruction), 32'(m_word));
        chk("cpu_hold", 32'(cpu_hold), 32'(!m_done));
        chk("done", 32'(done), 32'(m_done));
        chk("error", 32'(error), 32'(m_err));
        chk("loaded_count", 32'(loaded_count), 32'(m_cnt));
        if (write === 1'b1) begin
            cap_idx.push_back(write_instruction_index);
            cap_dat.push_back(write_instruction);
        end
        if (reset) begin
            m_active = 0; m_done = 0; m_err = 0; m_pend = 0; m_pos = 0;
            m_cnt = 0; m_idx = 8'(BASE); m_word = 0;
        end else if (m_pend) begin
            m_pend = 0;
            m_cnt++;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_done = 0; m_err = 0; m_cnt = 0; m_pos = 0; m_acc = 0;
            end
        end else if (rx_if.rx_valid && exp_ready) begin
            b = rx_if.rx_data;
            if (m_pos == 0) begin
                m_n = b; m_acc = b;
                if (b == 0 || int'(b) > MAXW) begin m_active = 0; m_err = 1; end
                else m_pos = 1;
            end else if (m_pos <= 2 * int'(m_n)) begin
                m_acc ^= b;
                if (m_pos % 2 == 1) m_hi = b;
                else begin
                    m_pend = 1; m_word = {m_hi, b}; m_idx = 8'(BASE + int'(m_cnt));
                end
                m_pos++;
            end else begin
                m_active = 0;
                if (b == m_acc) m_done = 1; else m_err = 1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit cont);
        int t = 0;
        if (!cont && $urandom_range(0, 1) == 1) begin
            rx_if.rx_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        rx_if.rx_valid = 1'b1;
        rx_if.rx_data  = b;
        forever begin
            @(negedge clk);
            if (rx_if.rx_ready) break;
            t++;
            if (t > 50) begin
                errors++; checks++;
                $display("FAIL byte_timeout: rx_ready stayed 0 for byte %0h", b);
                rx_if.rx_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic send_bytes(input bq_t bs, input bit cont);
        foreach (bs[i]) send_byte(bs[i], cont);
        rx_if.rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic bq_t build(input logic [7:0] len, input bq_t data, input logic [7:0] flip);
        bq_t f;
        logic [7:0] x = len;
        f.push_back(len);
        foreach (data[i]) begin f.push_back(data[i]); x ^= data[i]; end
        f.push_back(x ^ flip);
        return f;
    endfunction

    function automatic bq_t rand_data(input int words);
        bq_t d;
        for (int i = 0; i < 2 * words; i++) d.push_back(8'($urandom_range(0, 255)));
        return d;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_if.rx_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        bq_t chaser, fr;
        chaser = '{8'h20, 8'h21, 8'h00, 8'h22, 8'h00, 8'h23, 8'h20, 8'h2B, 8'hFA, 8'hD0,
                   8'h52, 8'h00, 8'h10, 8'h2B, 8'h00, 8'hDA, 8'h01, 8'h32, 8'h01, 8'h33,
                   8'h0A, 8'h60, 8'hF6, 8'hE7, 8'hFE, 8'hE7};
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_index", 32'(write_instruction_index), 32'(BASE));
        chk("reset_hold", 32'(cpu_hold), 32'd1);

        // Chaser image
        cap_idx.delete(); cap_dat.delete();
        pulse_start();
        send_bytes(build(8'h0D, chaser, 8'h00), 1'b0);
        chk("chaser_writes", 32'(cap_dat.size()), 32'd13);
        if (cap_dat.size() == 13) begin
            chk("chaser_first_word", 32'(cap_dat[0]), 32'h2021);
            chk("chaser_first_idx", 32'(cap_idx[0]), 32'd10);
            chk("chaser_last_word", 32'(cap_dat[12]), 32'hFEE7);
            chk("chaser_last_idx", 32'(cap_idx[12]), 32'd22);
        end
        chk("chaser_count", 32'(loaded_count), 32'd13);
        chk("chaser_done", 32'(done), 32'd1);
        chk("chaser_hold", 32'(cpu_hold), 32'd0);

        // Bad checksum, then recovery
        cap_dat.delete(); cap_idx.delete();
        pulse_start();
        send_bytes(build(8'h0D, chaser, 8'h01), 1'b0);
        chk("badchk_writes", 32'(cap_dat.size()), 32'd13);
        chk("badchk_error", 32'(error), 32'd1);
        chk("badchk_done", 32'(done), 32'd0);
        chk("badchk_hold", 32'(cpu_hold), 32'd1);
        pulse_start();
        send_bytes(build(8'h0D, chaser, 8'h00), 1'b0);
        chk("recover_done", 32'(done), 32'd1);

        // Length errors and maximum length
        cap_dat.delete(); cap_idx.delete();
        pulse_start();
        send_bytes('{8'h00}, 1'b0);
        chk("len0_error", 32'(error), 32'd1);
        pulse_start();
        send_bytes('{8'(MAXW + 1)}, 1'b0);
        chk("lenmax1_error", 32'(error), 32'd1);
        chk("lenerr_nowrite", 32'(cap_dat.size()), 32'd0);
        pulse_start();
        send_bytes(build(8'(MAXW), rand_data(MAXW), 8'h00), 1'b0);
        chk("lenmax_done", 32'(done), 32'd1);
        chk("lenmax_count", 32'(loaded_count), 32'(MAXW));

        // Continuous rx_valid: bytes wait through write cycles
        cap_dat.delete(); cap_idx.delete();
        pulse_start();
        send_bytes(build(8'd8, rand_data(8), 8'h00), 1'b1);
        chk("bp_writes", 32'(cap_dat.size()), 32'd8);
        chk("bp_done", 32'(done), 32'd1);

        // Reset after 3 of 5 words
        cap_dat.delete(); cap_idx.delete();
        pulse_start();
        fr = rand_data(3);
        send_byte(8'd5, 1'b0);
        foreach (fr[i]) send_byte(fr[i], 1'b0);
        rx_if.rx_valid = 1'b0;
        @(posedge clk); #1;
        chk("midload_writes", 32'(cap_dat.size()), 32'd3);
        do_reset();
        chk("midload_count", 32'(loaded_count), 32'd0);
        chk("midload_index", 32'(write_instruction_index), 32'(BASE));
        cap_dat.delete(); cap_idx.delete();
        pulse_start();
        send_bytes(build(8'd5, rand_data(5), 8'h00), 1'b0);
        chk("reload_done", 32'(done), 32'd1);
        if (cap_idx.size() > 0) chk("reload_first_idx", 32'(cap_idx[0]), 32'd10);

        // rx_valid while IDLE, start during WAIT_HI
        do_reset();
        rx_if.rx_valid = 1'b1; rx_if.rx_data = 8'h55;
        repeat (4) @(posedge clk);
        #1;
        rx_if.rx_valid = 1'b0;
        fr = build(8'd4, rand_data(4), 8'h00);
        pulse_start();
        send_byte(fr[0], 1'b0);
        rx_if.rx_valid = 1'b0;
        pulse_start();
        fr.pop_front();
        send_bytes(fr, 1'b0);
        chk("ignored_done", 32'(done), 32'd1);
        chk("ignored_count", 32'(loaded_count), 32'd4);

        // Random frames, some with corrupted checksums
        for (int k = 0; k < 6; k++) begin
            int n = $urandom_range(1, 20);
            pulse_start();
            send_bytes(build(8'(n), rand_data(n), 8'($urandom_range(0, 1))), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
